// File: rtl/pwm_multichan_pkg.sv
// Shared constants for the multi-channel PWM block: configuration address
// map, mode encoding and the center-mode count direction.
package pwm_multichan_pkg;

    localparam logic [4:0] ADDR_PERIOD = 5'd0;
    localparam logic [4:0] ADDR_MODE   = 5'd1;
    localparam logic [4:0] ADDR_DUTY0  = 5'd2;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } cnt_dir_e;

endpackage

// File: rtl/pwm_multichan_if.sv
// Configuration write bus: one register write per cycle when cfg_we is high.
interface pwm_multichan_if #(
    parameter int CNT_W = 16
);
    logic             cfg_we;
    logic [4:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_wdata;

    modport master (output cfg_we, output cfg_addr, output cfg_wdata);
    modport slave  (input  cfg_we, input  cfg_addr, input  cfg_wdata);
endinterface

// File: rtl/pwm_multichan_cmp_chan.sv
// One PWM channel: shadow/active duty pair, duty comparator, optional
// inversion and the registered output.
module pwm_cmp_chan #(
    parameter int   CNT_W = 16,
    parameter logic INV   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             load,
    input  logic             run,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] period,
    output logic             pwm_out
);
    logic [CNT_W-1:0] duty_sh_reg;
    logic [CNT_W-1:0] duty_sh_next;
    logic [CNT_W-1:0] duty_act_reg;
    logic             raw;

    // A write landing on the load cycle goes straight through to the active copy.
    assign duty_sh_next = wr_en ? wr_data : duty_sh_reg;

    // duty >= period forces high so center mode stays high at its peak count too.
    assign raw = run && ((cnt < duty_act_reg) || (duty_act_reg >= period));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh_reg  <= '0;
            duty_act_reg <= '0;
            pwm_out      <= INV;
        end else begin
            duty_sh_reg <= duty_sh_next;
            if (load) begin
                duty_act_reg <= duty_sh_next;
            end
            pwm_out <= raw ^ INV;
        end
    end

endmodule

// File: rtl/pwm_multichan.sv
// Multi-channel PWM generator: one shared edge/center-aligned counter with
// shadowed period and mode, swapped into the active set at period boundaries.
module pwm_multichan
    import pwm_multichan_pkg::*;
#(
    parameter int              N_CH     = 4,
    parameter int              CNT_W    = 16,
    parameter logic [N_CH-1:0] INV_MASK = {N_CH{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    pwm_multichan_if.slave  cfg,
    output logic [N_CH-1:0] pwm_out,
    output logic            cycle_start
);
    logic [CNT_W-1:0] period_sh_reg;
    logic [CNT_W-1:0] period_sh_next;
    logic [CNT_W-1:0] period_act_reg;
    pwm_mode_e        mode_sh_reg;
    pwm_mode_e        mode_sh_next;
    pwm_mode_e        mode_act_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    cnt_dir_e         dir_reg;
    cnt_dir_e         dir_next;
    logic             run;
    logic             boundary;
    logic             load;

    assign period_sh_next = (cfg.cfg_we && cfg.cfg_addr == ADDR_PERIOD) ? cfg.cfg_wdata : period_sh_reg;
    assign mode_sh_next   = (cfg.cfg_we && cfg.cfg_addr == ADDR_MODE)
                          ? pwm_mode_e'(cfg.cfg_wdata[0]) : mode_sh_reg;

    assign run = en && (period_act_reg != '0);

    // Center mode ends on the way down at 1; with P==1 the peak itself is the end.
    always_comb begin
        boundary = 1'b0;
        if (run) begin
            if (mode_act_reg == MODE_EDGE) begin
                boundary = (cnt_reg == period_act_reg - CNT_W'(1));
            end else begin
                boundary = (cnt_reg == CNT_W'(1)) &&
                           ((dir_reg == DIR_DOWN) || (period_act_reg == CNT_W'(1)));
            end
        end
    end

    // Idle or invalid period keeps the active set tracking the shadows every cycle.
    assign load = !run || boundary;

    always_comb begin
        cnt_next = cnt_reg;
        dir_next = dir_reg;
        if (load) begin
            cnt_next = '0;
            dir_next = DIR_UP;
        end else if (mode_act_reg == MODE_EDGE) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end else if (dir_reg == DIR_UP) begin
            if (cnt_reg == period_act_reg) begin
                dir_next = DIR_DOWN;
                cnt_next = cnt_reg - CNT_W'(1);
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end else begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_sh_reg  <= '0;
            period_act_reg <= '0;
            mode_sh_reg    <= MODE_EDGE;
            mode_act_reg   <= MODE_EDGE;
            cnt_reg        <= '0;
            dir_reg        <= DIR_UP;
            cycle_start    <= 1'b0;
        end else begin
            period_sh_reg <= period_sh_next;
            mode_sh_reg   <= mode_sh_next;
            if (load) begin
                period_act_reg <= period_sh_next;
                mode_act_reg   <= mode_sh_next;
            end
            cnt_reg     <= cnt_next;
            dir_reg     <= dir_next;
            cycle_start <= run && (cnt_reg == '0);
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            pwm_cmp_chan #(
                .CNT_W (CNT_W),
                .INV   (INV_MASK[gi])
            ) u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en   (cfg.cfg_we && (cfg.cfg_addr == ADDR_DUTY0 + 5'(gi))),
                .wr_data (cfg.cfg_wdata),
                .load    (load),
                .run     (run),
                .cnt     (cnt_reg),
                .period  (period_act_reg),
                .pwm_out (pwm_out[gi])
            );
        end
    endgenerate

endmodule
